uart_cmd_fifo: RTL and testbench

//   Buffers command bytes from the UART receiver (uartRX) for the CPU. Detects the rising

---
 rtl/uart_cmd_fifo.sv | 60 ++++++
 tb/tb_uart_cmd_fifo.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_fifo.sv
// uart_cmd_fifo: edge-detected, optionally move-filtered show-ahead command FIFO between uartRX and the CPU
module uart_cmd_fifo #(
  parameter int DEPTH = 16,
  parameter bit FILTER_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic                     pop,
  input  logic                     clr_ovf,
  output logic [31:0]              rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [3:0]               last_dir
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          rx_valid_q;
  logic          push_req, is_move, qual, do_push, do_pop;
  logic [3:0]    dir;
  always_comb begin
    dir = rx_data == 8'h55 ? 4'b0001 :
          rx_data == 8'h44 ? 4'b0010 :
          rx_data == 8'h4C ? 4'b0100 :
          rx_data == 8'h52 ? 4'b1000 : 4'b0000;
    is_move  = |dir;
    push_req = rx_valid & ~rx_valid_q;
    qual     = push_req & (!FILTER_EN || is_move);
    empty    = count == '0;
    full     = count == CW'(DEPTH);
    do_pop   = pop & ~empty;
    do_push  = qual & (~full | do_pop);
    rd_data  = empty ? 32'h0 : {24'h0, mem[rd_ptr]};
  end
  // Storage is deliberately unreset; empty masks stale contents on rd_data.
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= rx_data;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rx_valid_q <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      last_dir   <= 4'b0000;
    end else begin
      rx_valid_q <= rx_valid;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
      if (qual) last_dir <= dir;
      if (qual & full & ~do_pop) overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
endmodule

// File: tb/tb_uart_cmd_fifo.sv
// tb_uart_cmd_fifo: directed self-checking bench for uart_cmd_fifo
module tb_uart_cmd_fifo;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        pop = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [31:0] rd_data;
  logic        empty, full, overflow;
  logic [4:0]  count;
  logic [3:0]  last_dir;
  int checks = 0;
  int errors = 0;

  uart_cmd_fifo #(.DEPTH(16), .FILTER_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .pop(pop),
    .clr_ovf(clr_ovf), .rd_data(rd_data), .empty(empty), .full(full),
    .count(count), .overflow(overflow), .last_dir(last_dir)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic pop_once();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_dir", last_dir, 0);
    chk("rst_rd", rd_data, 0);

    rx_data = 8'h55;
    rx_valid = 1'b1;
    tick();
    chk("u_lat_count", count, 1);
    chk("u_lat_empty", empty, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("u_hold_count", count, 1);
    chk("u_rd", rd_data, 32'h55);
    chk("u_dir", last_dir, 4'b0001);
    rx_valid = 1'b0;
    tick();

    send(8'h41);
    chk("flt_count", count, 1);
    chk("flt_rd", rd_data, 32'h55);
    chk("flt_dir", last_dir, 4'b0001);
    chk("flt_ovf", overflow, 0);

    pop_once();
    chk("pop_empty", empty, 1);
    chk("pop_rd", rd_data, 0);
    pop_once();
    chk("pop_mt_count", count, 0);

    for (int i = 0; i < 16; i++) send(8'h44);
    chk("fill_count", count, 16);
    chk("fill_full", full, 1);
    chk("fill_rd", rd_data, 32'h44);
    chk("fill_dir", last_dir, 4'b0010);
    chk("fill_ovf", overflow, 0);
    send(8'h52);
    chk("drop_count", count, 16);
    chk("drop_ovf", overflow, 1);
    chk("drop_dir", last_dir, 4'b1000);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("clr_ovf", overflow, 0);

    rx_data = 8'h55;
    rx_valid = 1'b1;
    clr_ovf = 1'b1;
    tick();
    chk("setwins_ovf", overflow, 1);
    chk("setwins_dir", last_dir, 4'b0001);
    rx_valid = 1'b0;
    tick();
    clr_ovf = 1'b0;
    chk("clr2_ovf", overflow, 0);

    rx_data = 8'h4C;
    rx_valid = 1'b1;
    pop = 1'b1;
    tick();
    rx_valid = 1'b0;
    pop = 1'b0;
    tick();
    chk("fullpp_count", count, 16);
    chk("fullpp_ovf", overflow, 0);
    chk("fullpp_rd", rd_data, 32'h44);
    for (int i = 0; i < 15; i++) pop_once();
    chk("drain_count", count, 1);
    chk("drain_last", rd_data, 32'h4C);
    pop_once();
    chk("drain_empty", empty, 1);

    for (int i = 0; i < 12; i++) begin
      rx_data = 8'h55;
      rx_valid = 1'b1;
      pop = 1'b1;
      tick();
      if (i == 0) chk("mtpp_count", count, 1);
      rx_valid = 1'b0;
      tick();
      pop = 1'b0;
    end
    chk("pairs_count", count, 0);
    send(8'h55);
    send(8'h44);
    send(8'h4C);
    send(8'h52);
    chk("wrap_count", count, 4);
    chk("wrap_rd0", rd_data, 32'h55);
    pop_once();
    chk("wrap_rd1", rd_data, 32'h44);
    pop_once();
    chk("wrap_rd2", rd_data, 32'h4C);
    pop_once();
    chk("wrap_rd3", rd_data, 32'h52);
    pop_once();
    chk("wrap_empty", empty, 1);
    chk("wrap_rd_mt", rd_data, 0);
    pop_once();
    chk("wrap_xpop", count, 0);

    send(8'h55);
    send(8'h44);
    send(8'h4C);
    chk("pre_rst_count", count, 3);
    chk("pre_rst_dir", last_dir, 4'b0100);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_ovf", overflow, 0);
    chk("arst_dir", last_dir, 0);
    chk("arst_rd", rd_data, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
